alu_issue_stage: RTL and testbench

Two-stage operand-issue / result-capture pipeline wrapped around the combinational 32-bit ALU (K_ALU_32) in the execute path. It accepts decoded operations from the decode stage, sign/zero-extends immediates, forwards in-flight results to resolve back-to-back dependencies, drives the ALU's A/B/sel inputs from a registered stage, and captures the ALU result into an output register for writeback. Valid/ready handshakes on both sides allow back-pressure from writeback without losing operations.

---
 rtl/alu_issue_stage.sv | 130 +++++++++++++
 tb/tb_alu_issue_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Two-stage issue/capture pipeline around the external combinational 32-bit ALU.
// S1 registers forwarded operands for the ALU; S2 captures the result for writeback.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_sel,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic [4:0]  in_rs_idx,
  input  logic [4:0]  in_rt_idx,
  input  logic [15:0] in_imm,
  input  logic        in_use_imm,
  input  logic        in_imm_zext,
  input  logic [4:0]  in_rd,
  input  logic        in_wb_en,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic [15:0] op_count,
  output logic [15:0] stall_count
);

  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [3:0]  s1_sel;
  logic [4:0]  s1_rd;
  logic        s1_wb_en;

  logic        s2_valid;
  logic [31:0] s2_res;
  logic [4:0]  s2_rd;
  logic        s2_wb_en;

  logic        s2_adv;
  logic        s1_adv;
  logic        accept;
  logic [31:0] ext_imm;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  assign ext_imm = in_imm_zext ? {16'h0000, in_imm} : {{16{in_imm[15]}}, in_imm};

  // The youngest in-flight producer wins: S1 (result still in the ALU) before S2.
  always_comb begin
    fwd_a = in_rs_val;
    fwd_b = in_rt_val;
    if (in_rs_idx != 5'd0 && s1_valid && s1_wb_en && s1_rd == in_rs_idx)
      fwd_a = alu_res;
    else if (in_rs_idx != 5'd0 && s2_valid && s2_wb_en && s2_rd == in_rs_idx)
      fwd_a = s2_res;
    if (in_rt_idx != 5'd0 && s1_valid && s1_wb_en && s1_rd == in_rt_idx)
      fwd_b = alu_res;
    else if (in_rt_idx != 5'd0 && s2_valid && s2_wb_en && s2_rd == in_rt_idx)
      fwd_b = s2_res;
    op_b = in_use_imm ? ext_imm : fwd_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= 32'h0;
      s1_b     <= 32'h0;
      s1_sel   <= 4'h0;
      s1_rd    <= 5'h0;
      s1_wb_en <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= fwd_a;
      s1_b     <= op_b;
      s1_sel   <= in_sel;
      s1_rd    <= in_rd;
      s1_wb_en <= in_wb_en;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Data fields are only written on a load, so a stalled result stays intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= 32'h0;
      s2_rd    <= 5'h0;
      s2_wb_en <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_res   <= alu_res;
      s2_rd    <= s1_rd;
      s2_wb_en <= s1_wb_en;
    end else if (s2_adv) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= 16'h0;
      stall_count <= 16'h0;
    end else begin
      if (s2_valid && out_ready)
        op_count <= op_count + 16'd1;
      if (s2_valid && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  assign alu_A     = s1_a;
  assign alu_B     = s1_b;
  assign alu_sel   = s1_sel;
  assign out_valid = s2_valid;
  assign out_res   = s2_res;
  assign out_rd    = s2_rd;
  assign out_wb_en = s2_wb_en;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps plus a random stream checked against
// an in-order architectural register model; the ALU itself is modelled here.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [4:0]  in_rs_idx;
  logic [4:0]  in_rt_idx;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        in_imm_zext;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [3:0]  alu_sel;
  logic [31:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [15:0] op_count;
  logic [15:0] stall_count;

  logic [31:0] drv_rs_val;
  logic [31:0] drv_rt_val;
  logic        use_rf;
  logic [31:0] rf [32];
  logic [31:0] arch [32];

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb_en;
  } exp_t;
  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      default: return ~(a | b);
    endcase
  endfunction

  // Decode presents register-file contents (random phases) or hand-picked stale values.
  assign in_rs_val = use_rf ? rf[in_rs_idx] : drv_rs_val;
  assign in_rt_val = use_rf ? rf[in_rt_idx] : drv_rt_val;
  assign alu_res   = alu_fn(alu_A, alu_B, alu_sel);

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_imm_zext(in_imm_zext),
    .in_rd(in_rd), .in_wb_en(in_wb_en),
    .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wb_en(out_wb_en),
    .op_count(op_count), .stall_count(stall_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] rs_val,
                               input logic [4:0] rs_idx, input logic [31:0] rt_val,
                               input logic [4:0] rt_idx, input logic [15:0] imm,
                               input logic use_imm, input logic zext,
                               input logic [4:0] rd, input logic wb_en);
    in_sel      = sel;
    drv_rs_val  = rs_val;
    in_rs_idx   = rs_idx;
    drv_rt_val  = rt_val;
    in_rt_idx   = rt_idx;
    in_imm      = imm;
    in_use_imm  = use_imm;
    in_imm_zext = zext;
    in_rd       = rd;
    in_wb_en    = wb_en;
    in_valid    = 1'b1;
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    applyStimulus(4'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom),
                  16'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    for (int i = 0; i < 32; i++) begin
      rf[i]   = 32'h0;
      arch[i] = 32'h0;
    end
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference semantics: each op reads the architectural registers as left by all older ops.
  task automatic modelStep(inout int issued, inout int retired);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm32;
    exp_t e;
    if (in_valid && in_ready) begin
      imm32 = {16'h0000, in_imm};
      if (!in_imm_zext && in_imm >= 16'h8000)
        imm32 = imm32 - 32'h0001_0000;
      a = arch[in_rs_idx];
      b = in_use_imm ? imm32 : arch[in_rt_idx];
      e.res   = alu_fn(a, b, in_sel);
      e.rd    = in_rd;
      e.wb_en = in_wb_en;
      sb.push_back(e);
      if (in_wb_en && in_rd != 5'd0)
        arch[in_rd] = e.res;
      issued++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("rand_unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("rand_res_%0d", retired), out_res, e.res);
        checkOutput($sformatf("rand_rd_%0d", retired), 32'(out_rd), 32'(e.rd));
        checkOutput($sformatf("rand_wben_%0d", retired), 32'(out_wb_en), 32'(e.wb_en));
      end
      if (out_wb_en && out_rd != 5'd0)
        rf[out_rd] = out_res;
      retired++;
    end
  endtask

  task automatic runRandom(input int n_ops, input bit rnd_flow, input string tag);
    int issued = 0;
    int retired = 0;
    bit have = 1'b0;
    for (int c = 0; c < 4000 && retired < n_ops; c++) begin
      if (!have && issued < n_ops && (!rnd_flow || $urandom_range(0, 3) != 0)) begin
        applyStimulus(4'($urandom_range(0, 10)), 32'h0, 5'($urandom_range(0, 3)),
                      32'h0, 5'($urandom_range(0, 3)), 16'($urandom), 1'($urandom),
                      1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        have = 1'b1;
      end
      in_valid  = have;
      out_ready = rnd_flow ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready)
        have = 1'b0;
      modelStep(issued, retired);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_retired"}, 32'(retired), 32'(n_ops));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int issued;
    int got;
    bit seen;

    $display("[TB] reset checks");
    use_rf = 1'b0;
    assertReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_alu_A", alu_A, 32'h0);
    checkOutput("rst_alu_B", alu_B, 32'h0);
    checkOutput("rst_alu_sel", 32'(alu_sel), 32'h0);
    checkOutput("rst_out_res", out_res, 32'h0);
    checkOutput("rst_op_count", 32'(op_count), 32'h0);
    checkOutput("rst_stall_count", 32'(stall_count), 32'h0);
    releaseReset();

    $display("[TB] immediate extension");
    out_ready = 1'b1;
    applyStimulus(4'd0, 32'd5, 5'd0, 32'h0, 5'd0, 16'hFFFF, 1'b1, 1'b0, 5'd1, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    checkOutput("addi_sext_aluA", alu_A, 32'd5);
    checkOutput("addi_sext_aluB", alu_B, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    checkOutput("addi_sext_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_sext_res", out_res, 32'd4);
    applyStimulus(4'd0, 32'd5, 5'd0, 32'h0, 5'd0, 16'hFFFF, 1'b1, 1'b1, 5'd1, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    checkOutput("addi_zext_aluB", alu_B, 32'h0000_FFFF);
    @(posedge clk); #1;
    checkOutput("addi_zext_res", out_res, 32'h0001_0004);

    $display("[TB] forwarding");
    applyStimulus(4'd0, 32'd7, 5'd0, 32'h0, 5'd0, 16'd1, 1'b1, 1'b0, 5'd3, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd0, 32'd0, 5'd3, 32'h0, 5'd0, 16'd2, 1'b1, 1'b0, 5'd4, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    checkOutput("fwd_s1_op1_res", out_res, 32'd8);
    checkOutput("fwd_s1_aluA", alu_A, 32'd8);
    @(posedge clk); #1;
    checkOutput("fwd_s1_res", out_res, 32'd10);
    checkOutput("fwd_s1_rd", 32'(out_rd), 32'd4);

    applyStimulus(4'd0, 32'd7, 5'd0, 32'h0, 5'd0, 16'd1, 1'b1, 1'b0, 5'd3, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    applyStimulus(4'd0, 32'd0, 5'd3, 32'h0, 5'd0, 16'd2, 1'b1, 1'b0, 5'd4, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("fwd_s2_res", out_res, 32'd10);

    applyStimulus(4'd0, 32'd7, 5'd0, 32'h0, 5'd0, 16'd1, 1'b1, 1'b0, 5'd0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd0, 32'd0, 5'd0, 32'h0, 5'd0, 16'd2, 1'b1, 1'b0, 5'd4, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("fwd_r0_res", out_res, 32'd2);

    applyStimulus(4'd0, 32'd7, 5'd0, 32'h0, 5'd0, 16'd1, 1'b1, 1'b0, 5'd3, 1'b0);
    @(posedge clk); #1;
    applyStimulus(4'd1, 32'd0, 5'd0, 32'd0, 5'd3, 16'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("fwd_nowb_rt_res", out_res, 32'd0);

    $display("[TB] back-pressure");
    assertReset();
    releaseReset();
    out_ready = 1'b0;
    issued = 0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 7);
      if (issued < 4)
        applyStimulus(4'd0, 32'(100 + issued), 5'd0, 32'h0, 5'd0, 16'(issued), 1'b1, 1'b0,
                      5'(8 + issued), 1'b1);
      else
        in_valid = 1'b0;
      if (c == 7)
        checkOutput("bp_stall_count", 32'(stall_count), 32'd5);
      @(negedge clk);
      if (c == 2)
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (c == 7)
        checkOutput("bp_in_ready_rise", 32'(in_ready), 32'd1);
      if (in_valid && in_ready)
        issued++;
      if (out_valid && out_ready) begin
        if (got < 4)
          checkOutput($sformatf("bp_res_%0d", got), out_res, 32'(100 + 2 * got));
        got++;
      end
      @(posedge clk); #1;
    end
    checkOutput("bp_results", 32'(got), 32'd4);
    checkOutput("bp_op_count", 32'(op_count), 32'd4);
    checkOutput("bp_stall_final", 32'(stall_count), 32'd5);

    $display("[TB] random streams");
    assertReset();
    releaseReset();
    use_rf = 1'b1;
    runRandom(100, 1'b0, "rand_full_rate");
    checkOutput("rand_full_op_count", 32'(op_count), 32'd100);
    checkOutput("rand_full_stalls", 32'(stall_count), 32'd0);
    runRandom(100, 1'b1, "rand_flow");
    checkOutput("rand_flow_op_count", 32'(op_count), 32'd200);
    use_rf = 1'b0;

    $display("[TB] async reset with full pipeline");
    out_ready = 1'b0;
    applyStimulus(4'd0, 32'd11, 5'd0, 32'h0, 5'd0, 16'd1, 1'b1, 1'b0, 5'd5, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd0, 32'd21, 5'd0, 32'h0, 5'd0, 16'd1, 1'b1, 1'b0, 5'd6, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    checkOutput("ar_full_valid", 32'(out_valid), 32'd1);
    checkOutput("ar_full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_in_ready", 32'(in_ready), 32'd1);
    checkOutput("ar_alu_A", alu_A, 32'h0);
    checkOutput("ar_out_res", out_res, 32'h0);
    checkOutput("ar_op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid)
        seen = 1'b1;
    end
    checkOutput("ar_no_stale", 32'(seen), 32'd0);
    checkOutput("ar_op_count_after", 32'(op_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
